// File: rtl/branch_predictor_unit.sv
// -----------------------------------------------------------------------------
// branch_predictor_unit
//
// EX-stage branch resolution combined with a direct-mapped branch target
// buffer (BTB). Fetch receives a same-cycle taken/target prediction. EX
// computes PC+Imm and PC+4, detects a mispredict and drives a redirect.
// Saturating statistics count resolved branches and mispredicts.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   if_pc           fetch PC to predict
//   if_pred_taken   predicted taken for if_pc
//   if_pred_target  predicted target (0 when not predicted taken)
//   ex_valid        EX holds a valid instruction
//   ex_branch       EX instruction is a conditional branch
//   ex_pc, ex_imm   EX PC and branch immediate
//   ex_cond         ALU compare result (branch condition)
//   ex_pred_*       prediction that travelled down the pipe with the branch
//   pc_imm, pc_four zero-extended ex_pc + ex_imm, ex_pc + 4 (32-bit wrap)
//   redirect        mispredict: flush and load redirect_pc
//   redirect_pc     architecturally correct next PC
//   br_count        resolved conditional branches (saturating)
//   mispred_count   mispredicted branches (saturating)
//
// Handshake: none. Every input is sampled each cycle. A branch is resolved
// when ex_valid && ex_branch are both high; that cycle's outputs are valid
// combinationally and the BTB/statistics update on the following rising edge.
// -----------------------------------------------------------------------------
module branch_predictor_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    output logic [31:0]       if_pred_target,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic              ex_cond,
    input  logic              ex_pred_taken,
    input  logic [31:0]       ex_pred_target,
    output logic [31:0]       pc_imm,
    output logic [31:0]       pc_four,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // BTB storage
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [CNT_W-1:0]  r_cnt    [ENTRIES];

    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_mispred_count;

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_hit;
    logic [31:0]       w_ex_pc32;
    logic              w_res;
    logic              w_taken;
    logic              w_unused_pc_bits;

    // Instructions are word aligned; the low two PC bits carry no index/tag.
    assign w_unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // ---------------- prediction (fetch) ----------------
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[PC_W-1:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    // Counter MSB set means taken-leaning (weakly or strongly taken).
    assign if_pred_taken  = w_if_hit && r_cnt[w_if_idx][CNT_W-1];
    assign if_pred_target = if_pred_taken ? r_target[w_if_idx] : 32'd0;

    // ---------------- resolution (EX) ----------------
    assign w_ex_pc32 = 32'(ex_pc);
    assign pc_imm    = w_ex_pc32 + ex_imm;
    assign pc_four   = w_ex_pc32 + 32'd4;

    assign w_res   = ex_valid && ex_branch;
    assign w_taken = w_res && ex_cond;

    // A correctly predicted direction can still mispredict if the BTB held a
    // stale target for a taken branch.
    assign redirect    = w_res && ((w_taken != ex_pred_taken) ||
                                   (w_taken && (ex_pred_target != pc_imm)));
    assign redirect_pc = w_taken ? pc_imm : pc_four;

    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[PC_W-1:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    // ---------------- update ----------------
    // Fetch reads the arrays combinationally, so a same-index write in this
    // cycle only becomes visible after the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else if (w_res) begin
            if (w_ex_hit) begin
                if (w_taken) begin
                    r_target[w_ex_idx] <= pc_imm;
                    if (r_cnt[w_ex_idx] != CNT_MAX)
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + CNT_W'(1);
                end else if (r_cnt[w_ex_idx] != '0) begin
                    r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - CNT_W'(1);
                end
            end else if (w_taken) begin
                // Allocate (or evict an aliasing entry) as weakly taken.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= pc_imm;
                r_cnt[w_ex_idx]    <= CNT_WT;
            end

            if (r_br_count != STAT_MAX)
                r_br_count <= r_br_count + STAT_W'(1);
            if (redirect && (r_mispred_count != STAT_MAX))
                r_mispred_count <= r_mispred_count + STAT_W'(1);
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor_unit.sv
module tb_branch_predictor_unit;
  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int STAT_W  = 8;   // reduced so saturation is reachable quickly
  localparam int STAT_MAX = (1 << STAT_W) - 1;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int CTHRESH  = 1 << (CNT_W - 1);

  logic              clk;
  logic              reset;
  logic [PC_W-1:0]   if_pc;
  logic              if_pred_taken;
  logic [31:0]       if_pred_target;
  logic              ex_valid, ex_branch, ex_cond, ex_pred_taken;
  logic [PC_W-1:0]   ex_pc;
  logic [31:0]       ex_imm, ex_pred_target;
  logic [31:0]       pc_imm, pc_four, redirect_pc;
  logic              redirect;
  logic [STAT_W-1:0] br_count, mispred_count;

  branch_predictor_unit #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_cond(ex_cond), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .pc_imm(pc_imm), .pc_four(pc_four),
    .redirect(redirect), .redirect_pc(redirect_pc), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Table keyed by slot number; counters kept as plain integers.
  bit          m_v   [ENTRIES];
  int          m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];
  int          m_br, m_mis;

  // Expected combinational outputs for the inputs currently applied.
  logic        e_pt, e_redir;
  logic [31:0] e_ptg, e_pc_imm, e_pc_four, e_rpc;

  function automatic int slot_of(logic [PC_W-1:0] pc);
    return (int'(pc) / 4) % ENTRIES;
  endfunction

  function automatic int tag_of(logic [PC_W-1:0] pc);
    return int'(pc) / (4 * ENTRIES);
  endfunction

  task automatic model_predict(input logic [PC_W-1:0] pc, output logic t, output logic [31:0] tg);
    int s;
    s = slot_of(pc);
    t = m_v[s] && (m_tag[s] == tag_of(pc)) && (m_cnt[s] >= CTHRESH);
    tg = t ? m_tgt[s] : 32'd0;
  endtask

  task automatic model_eval();
    logic res, tk;
    model_predict(if_pc, e_pt, e_ptg);
    e_pc_imm  = 32'(ex_pc) + ex_imm;
    e_pc_four = 32'(ex_pc) + 32'd4;
    res = ex_valid && ex_branch;
    tk  = res && ex_cond;
    e_redir = res && ((tk != ex_pred_taken) || (tk && (ex_pred_target != e_pc_imm)));
    e_rpc = tk ? e_pc_imm : e_pc_four;
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_cnt[i] = CTHRESH - 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic model_commit();
    int s;
    bit hit;
    model_eval();
    if (ex_valid && ex_branch) begin
      s = slot_of(ex_pc);
      hit = m_v[s] && (m_tag[s] == tag_of(ex_pc));
      if (hit) begin
        if (ex_cond) begin
          m_cnt[s] = (m_cnt[s] < CMAX) ? m_cnt[s] + 1 : CMAX;
          m_tgt[s] = e_pc_imm;
        end else begin
          m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
        end
      end else if (ex_cond) begin
        m_v[s] = 1'b1; m_tag[s] = tag_of(ex_pc); m_tgt[s] = e_pc_imm; m_cnt[s] = CTHRESH;
      end
      if (m_br < STAT_MAX) m_br++;
      if (e_redir && m_mis < STAT_MAX) m_mis++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [PC_W-1:0] fpc, input logic v, input logic b,
                       input logic [PC_W-1:0] epc, input logic [31:0] imm, input logic cond,
                       input logic pt, input logic [31:0] ptg);
    @(negedge clk);
    if_pc = fpc; ex_valid = v; ex_branch = b; ex_pc = epc; ex_imm = imm;
    ex_cond = cond; ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    if_pc = 9'h010; ex_valid = 0; ex_branch = 0; ex_pc = '0; ex_imm = '0;
    ex_cond = 0; ex_pred_taken = 0; ex_pred_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %0b want 0", if_pred_taken); end
    n_cmp++; if (if_pred_target !== 32'd0) begin n_fail++; $display("FAIL reset_pred_target: got %h want 0", if_pred_target); end
    n_cmp++; if (br_count !== '0) begin n_fail++; $display("FAIL reset_br_count: got %0d want 0", br_count); end
    n_cmp++; if (mispred_count !== '0) begin n_fail++; $display("FAIL reset_mis_count: got %0d want 0", mispred_count); end
  endtask

  task automatic test_first_branch();
    drive(9'h010, 1, 1, 9'h010, 32'h20, 1, 0, 32'h0);
    n_cmp++; if (pc_imm !== 32'h30) begin n_fail++; $display("FAIL first_pc_imm: got %h want 30", pc_imm); end
    n_cmp++; if (pc_four !== 32'h14) begin n_fail++; $display("FAIL first_pc_four: got %h want 14", pc_four); end
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL first_redirect: got %0b want 1", redirect); end
    n_cmp++; if (redirect_pc !== 32'h30) begin n_fail++; $display("FAIL first_redirect_pc: got %h want 30", redirect_pc); end
    tick();
    drive(9'h010, 0, 0, 9'h010, 32'h20, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL first_learned_taken: got %0b want 1", if_pred_taken); end
    n_cmp++; if (if_pred_target !== 32'h30) begin n_fail++; $display("FAIL first_learned_target: got %h want 30", if_pred_target); end
    n_cmp++; if (br_count !== 8'd1 || mispred_count !== 8'd1) begin n_fail++; $display("FAIL first_counts: got %0d/%0d want 1/1", br_count, mispred_count); end
  endtask

  task automatic test_counter_training();
    for (int k = 0; k < 2; k++) begin
      drive(9'h010, 1, 1, 9'h010, 32'h20, 1, 1, 32'h30);
      n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL train_correct_%0d: got redirect %0b want 0", k, redirect); end
      tick();
    end
    drive(9'h010, 1, 1, 9'h010, 32'h20, 0, 1, 32'h30);
    n_cmp++; if (redirect !== 1'b1 || redirect_pc !== 32'h14) begin n_fail++; $display("FAIL train_nt1: got %0b/%h want 1/14", redirect, redirect_pc); end
    tick();
    drive(9'h010, 0, 0, 9'h010, 32'h20, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_still_taken: got %0b want 1", if_pred_taken); end
    drive(9'h010, 1, 1, 9'h010, 32'h20, 0, 1, 32'h30);
    n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL train_nt2: got %0b want 1", redirect); end
    tick();
    drive(9'h010, 0, 0, 9'h010, 32'h20, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b0 || if_pred_target !== 32'd0) begin n_fail++; $display("FAIL train_flipped: got %0b/%h want 0/0", if_pred_taken, if_pred_target); end
    n_cmp++; if (br_count !== 8'd5 || mispred_count !== 8'd3) begin n_fail++; $display("FAIL train_counts: got %0d/%0d want 5/3", br_count, mispred_count); end
  endtask

  task automatic test_aliasing();
    drive(9'h010, 1, 1, 9'h050, 32'h8, 1, 0, 32'h0);
    tick();
    drive(9'h010, 0, 0, 9'h050, 32'h8, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_other_tag: got %0b want 0", if_pred_taken); end
    drive(9'h050, 0, 0, 9'h050, 32'h8, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h58) begin n_fail++; $display("FAIL alias_alloc: got %0b/%h want 1/58", if_pred_taken, if_pred_target); end
    drive(9'h050, 1, 1, 9'h010, 32'h20, 1, 0, 32'h0);
    tick();
    drive(9'h010, 0, 0, 9'h010, 32'h20, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b1 || if_pred_target !== 32'h30) begin n_fail++; $display("FAIL alias_replace_new: got %0b/%h want 1/30", if_pred_taken, if_pred_target); end
    drive(9'h050, 0, 0, 9'h010, 32'h20, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_replace_old: got %0b want 0", if_pred_taken); end
  endtask

  task automatic test_same_cycle_hazard();
    // slot 4 holds 0x010 weakly taken; a not-taken resolution lowers it
    drive(9'h010, 1, 1, 9'h010, 32'h20, 0, 1, 32'h30);
    n_cmp++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL hazard_old_value: got %0b want 1", if_pred_taken); end
    tick();
    drive(9'h010, 0, 0, 9'h010, 32'h20, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL hazard_new_value: got %0b want 0", if_pred_taken); end
  endtask

  task automatic test_invalid_ex();
    int br0, mis0;
    br0 = m_br; mis0 = m_mis;
    drive(9'h090, 0, 1, 9'h090, 32'h40, 1, 0, 32'h0);
    n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL invalid_redirect: got %0b want 0", redirect); end
    tick();
    drive(9'h090, 0, 0, 9'h090, 32'h40, 0, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL invalid_no_alloc: got %0b want 0", if_pred_taken); end
    n_cmp++; if (int'(br_count) != br0 || int'(mispred_count) != mis0) begin n_fail++; $display("FAIL invalid_counts: got %0d/%0d want %0d/%0d", br_count, mispred_count, br0, mis0); end
  endtask

  task automatic test_random();
    logic [PC_W-1:0] fpc, epc;
    logic [31:0] imm, ptg;
    logic pt;
    for (int k = 0; k < 600; k++) begin
      fpc = PC_W'($urandom_range(0, 127) * 4);
      epc = PC_W'($urandom_range(0, 127) * 4);
      imm = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 128) * 4) - 32'd256;
      model_predict(epc, pt, ptg);
      if ($urandom_range(0, 7) == 0) begin pt = 1'($urandom()); ptg = $urandom(); end
      drive(fpc, $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, epc, imm, 1'($urandom()), pt, ptg);
      n_cmp++; if (if_pred_taken !== e_pt || if_pred_target !== e_ptg) begin n_fail++; $display("FAIL rand_pred[%0d]: got %0b/%h want %0b/%h", k, if_pred_taken, if_pred_target, e_pt, e_ptg); end
      n_cmp++; if (pc_imm !== e_pc_imm || pc_four !== e_pc_four) begin n_fail++; $display("FAIL rand_targets[%0d]: got %h/%h want %h/%h", k, pc_imm, pc_four, e_pc_imm, e_pc_four); end
      n_cmp++; if (redirect !== e_redir || redirect_pc !== e_rpc) begin n_fail++; $display("FAIL rand_redirect[%0d]: got %0b/%h want %0b/%h", k, redirect, redirect_pc, e_redir, e_rpc); end
      n_cmp++; if (int'(br_count) != m_br || int'(mispred_count) != m_mis) begin n_fail++; $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", k, br_count, mispred_count, m_br, m_mis); end
      tick();
    end
  endtask

  task automatic test_saturation();
    test_reset();
    for (int k = 0; k < STAT_MAX + 20; k++) begin
      drive(9'h010, 1, 1, 9'h010, 32'h20, 1, 0, 32'h0);
      tick();
    end
    drive(9'h010, 0, 0, 9'h010, 32'h20, 0, 0, 32'h0);
    n_cmp++; if (mispred_count !== 8'hFF || br_count !== 8'hFF) begin n_fail++; $display("FAIL sat_counts: got %0d/%0d want 255/255", br_count, mispred_count); end
    n_cmp++; if (int'(mispred_count) != m_mis) begin n_fail++; $display("FAIL sat_model: got %0d want %0d", mispred_count, m_mis); end
  endtask

  task automatic test_reset_midstream();
    drive(9'h010, 1, 1, 9'h010, 32'h20, 1, 0, 32'h0);
    n_cmp++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL mid_before: got %0b want 1", if_pred_taken); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (if_pred_taken !== 1'b0 || if_pred_target !== 32'd0) begin n_fail++; $display("FAIL mid_async_pred: got %0b/%h want 0/0", if_pred_taken, if_pred_target); end
    n_cmp++; if (br_count !== '0 || mispred_count !== '0) begin n_fail++; $display("FAIL mid_async_counts: got %0d/%0d want 0/0", br_count, mispred_count); end
    @(posedge clk);
    #1;
    n_cmp++; if (if_pred_taken !== 1'b0 || br_count !== '0) begin n_fail++; $display("FAIL mid_held: got %0b/%0d want 0/0", if_pred_taken, br_count); end
    @(negedge clk);
    reset = 1'b1; ex_valid = 1'b0;
    #1;
    n_cmp++; if (if_pred_taken !== 1'b0 || mispred_count !== '0) begin n_fail++; $display("FAIL mid_released: got %0b/%0d want 0/0", if_pred_taken, mispred_count); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_first_branch();
    test_counter_training();
    test_aliasing();
    test_same_cycle_hazard();
    test_invalid_ex();
    test_random();
    test_saturation();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
